// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the add-3 digit constants.
package bin2bcd_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;
  localparam logic [3:0]  ADD3_VAL    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_add3_digit.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
// Purely combinational; the 4-bit sum never needs a carry out.
module bcd_add3_digit
  import bin2bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= ADD3_THRESH) q = d + ADD3_VAL;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with valid/ready handshakes on input and output.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIN_W-1:0]       bin_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*DIGITS-1:0]    bcd_out,
  output logic                   busy
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [SCR_W-1:0]    scratch, scratch_nxt;
  logic [SCR_W-1:0]    adjusted;
  logic [SCR_W-1:0]    shifted;
  logic [BCD_W-1:0]    bcd_q, bcd_nxt;

  // Digit fields sit above the binary bits; only they receive the add-3 correction.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3_digit u_digit (
      .d (scratch [BIN_W + 4*i +: 4]),
      .q (adjusted[BIN_W + 4*i +: 4])
    );
  end

  assign adjusted[BIN_W-1:0] = scratch[BIN_W-1:0];
  assign shifted             = {adjusted[SCR_W-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      scratch <= '0;
      bcd_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      scratch <= scratch_nxt;
      bcd_q   <= bcd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    scratch_nxt = scratch;
    bcd_nxt     = bcd_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          scratch_nxt = {{BCD_W{1'b0}}, bin_in};
          cnt_nxt     = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_nxt = shifted;
        cnt_nxt     = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          bcd_nxt   = shifted[SCR_W-1 -: BCD_W];
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == SHIFT);
    out_valid = (state == DONE);
    bcd_out   = bcd_q;
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: default 8-bit/3-digit instance plus a
// 10-bit/4-digit instance, compared against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid_a = 1'b0, out_ready_a = 1'b0;
  logic [7:0]  bin_in_a = '0;
  logic        in_ready_a, out_valid_a, busy_a;
  logic [11:0] bcd_a;

  logic        in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic [9:0]  bin_in_b = '0;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [15:0] bcd_b;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .bin_in(bin_in_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .bcd_out(bcd_a), .busy(busy_a)
  );

  bin2bcd_seq #(.BIN_W(10), .DIGITS(4)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .bin_in(bin_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .bcd_out(bcd_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal digits by plain division, packed one digit per nibble.
  function automatic logic [31:0] model_bcd(input int unsigned v, input int unsigned nd);
    logic [31:0] r = '0;
    int unsigned x = v;
    for (int unsigned i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [31:0] b, input int unsigned nd);
    logic ok = 1'b1;
    for (int unsigned i = 0; i < nd; i++)
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake on one instance: accept, check latency/result, then hand off.
  task automatic run_conv(input bit wide, input int unsigned v);
    int unsigned bw = wide ? 10 : 8;
    int unsigned nd = wide ? 4 : 3;
    int unsigned n;
    logic [31:0] got;
    n = 0;
    while (!(wide ? in_ready_b : in_ready_a) && n < 30) begin tick(); n++; end
    check("in_ready_wait", 32'(wide ? in_ready_b : in_ready_a), 32'd1);
    if (wide) begin in_valid_b = 1'b1; bin_in_b = 10'(v); end
    else      begin in_valid_a = 1'b1; bin_in_a = 8'(v); end
    tick();
    // scramble the input after the accept edge; must not affect the result
    if (wide) begin in_valid_b = 1'b0; bin_in_b = 10'($urandom); end
    else      begin in_valid_a = 1'b0; bin_in_a = 8'($urandom); end
    check("busy_after_accept", 32'(wide ? busy_b : busy_a), 32'd1);
    n = 0;
    while (!(wide ? out_valid_b : out_valid_a) && n < 40) begin tick(); n++; end
    check("latency", n, bw);
    got = wide ? 32'(bcd_b) : 32'(bcd_a);
    check("bcd_value", got, model_bcd(v, nd));
    check("digits_le9", 32'(digits_ok(got, nd)), 32'd1);
    if (wide) out_ready_b = 1'b1; else out_ready_a = 1'b1;
    tick();
    if (wide) out_ready_b = 1'b0; else out_ready_a = 1'b0;
    check("out_valid_drop", 32'(wide ? out_valid_b : out_valid_a), 32'd0);
    check("bcd_kept_idle", wide ? 32'(bcd_b) : 32'(bcd_a), model_bcd(v, nd));
  endtask

  initial begin
    int unsigned n, acc, prev_acc;
    logic [15:0] ex3;

    rst_n = 1'b0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready_a), 32'd1);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_bcd", 32'(bcd_a), 32'd0);
    rst_n = 1'b1;
    tick();

    run_conv(0, 0);
    run_conv(0, 255);
    run_conv(0, 99);
    run_conv(0, 100);
    for (int i = 0; i < 12; i++) run_conv(0, $urandom_range(0, 255));

    // Result must stay parked while the consumer stalls; new requests ignored.
    in_valid_a = 1'b1; bin_in_a = 8'd42;
    tick();
    in_valid_a = 1'b0;
    n = 0;
    while (!out_valid_a && n < 40) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      in_valid_a = (i % 2 == 0); bin_in_a = 8'd7;
      tick();
      check("stall_out_valid", 32'(out_valid_a), 32'd1);
      check("stall_bcd", 32'(bcd_a), 32'h042);
      check("stall_in_ready", 32'(in_ready_a), 32'd0);
    end
    in_valid_a = 1'b0; out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    check("stall_release", 32'(in_ready_a), 32'd1);
    tick();
    check("no_late_accept", 32'(busy_a), 32'd0);

    // Reset during the fourth SHIFT cycle aborts the conversion.
    in_valid_a = 1'b1; bin_in_a = 8'd200;
    tick();
    in_valid_a = 1'b0;
    tick(); tick(); tick();
    check("mid_shift_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_in_ready", 32'(in_ready_a), 32'd1);
    check("abort_out_valid", 32'(out_valid_a), 32'd0);
    check("abort_bcd", 32'(bcd_a), 32'd0);
    run_conv(0, 137);

    // Back-to-back sweep with both handshakes held high.
    out_ready_a = 1'b1; in_valid_a = 1'b1; prev_acc = 0;
    for (int unsigned v = 0; v < 256; v++) begin
      bin_in_a = 8'(v);
      n = 0;
      while (!in_ready_a && n < 30) begin tick(); n++; end
      tick();
      acc = cyc;
      if (v > 0) check("sweep_period", acc - prev_acc, 32'd10);
      prev_acc = acc;
      bin_in_a = 8'(v + 1);
      n = 0;
      while (!out_valid_a && n < 40) begin tick(); n++; end
      check("sweep_bcd", 32'(bcd_a), model_bcd(v, 3));
      check("sweep_digits", 32'(digits_ok(32'(bcd_a), 3)), 32'd1);
    end
    in_valid_a = 1'b0;
    tick();
    out_ready_a = 1'b0;

    // Wide instance: 10-bit input, 4 digits.
    run_conv(1, 1023);
    for (int i = 0; i < 4; i++) ex3[4*i +: 4] = bcd_b[4*i +: 4] + 4'd3;
    check("excess3_1023", 32'(ex3), 32'h4356);
    for (int i = 0; i < 6; i++) run_conv(1, $urandom_range(0, 1023));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
